pwm_ramp_controller: RTL and testbench

Avalon-MM slave that sequences the 8-bit duty-cycle input of the PWM module. Software programs a target duty, a step size and a step period. The block then ramps `duty` toward the target in bounded increments (soft-start and soft-stop). When the target is reached it raises a maskable completion interrupt. It replaces a direct duty register wherever abrupt duty changes are not allowed.

---
 rtl/pwm_ramp_controller.sv | 189 ++++++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - Avalon-MM duty-cycle ramp sequencer for a PWM module
//
// Ramps an 8-bit PWM duty value toward a software-programmed target in bounded
// steps, one step every PERIOD+1 clocks, and raises a maskable completion irq.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   address    register select (0 TARGET, 1 STEP, 2 PERIOD, 3 CTRL/STATUS)
//   write      write strobe, writedata sampled on the same edge
//   writedata  write data
//   read       read strobe, readdata valid one cycle later
//   readdata   registered read data
//   duty       duty cycle to the PWM module
//   busy       high while ramping (UP or DOWN)
//   irq        irq_pend & irq_en

module pwm_ramp_controller #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  input  logic               read,
  output logic [31:0]        readdata,
  output logic [7:0]         duty,
  output logic               busy,
  output logic               irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           duty_q, duty_d;
  logic [7:0]           target_q, target_d;
  logic [7:0]           step_q, step_d;
  logic [PRESC_W-1:0]   period_q, period_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic                 enable_q, enable_d;
  logic                 irq_en_q, irq_en_d;
  logic                 irq_pend_q, irq_pend_d;
  logic                 busy_q;
  logic [31:0]          readdata_q, readdata_d;

  logic [7:0]           step_eff;
  logic [8:0]           sum9;
  logic [7:0]           diff8;
  logic                 tick;
  logic                 target_wr;
  logic [31:0]          status;

  // A programmed STEP of 0 would stall the ramp, so it behaves as 1.
  assign step_eff  = (step_q == 8'd0) ? 8'd1 : step_q;
  assign sum9      = {1'b0, duty_q} + {1'b0, step_eff};
  assign diff8     = duty_q - target_q;
  assign tick      = (presc_q == period_q);
  assign target_wr = write && (address == 2'd0);
  assign status    = {16'd0, duty_q, 4'd0, busy_q, irq_pend_q, irq_en_q, enable_q};

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    period_d   = period_q;
    presc_d    = presc_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    readdata_d = readdata_q;

    if (write) begin
      case (address)
        2'd0: target_d = writedata[7:0];
        2'd1: step_d   = writedata[7:0];
        2'd2: period_d = writedata[PRESC_W-1:0];
        default: begin
          enable_d = writedata[0];
          irq_en_d = writedata[1];
          if (writedata[2]) irq_pend_d = 1'b0;
        end
      endcase
    end

    // A new target aborts the current ramp without stepping; direction is
    // chosen again from IDLE on the following cycle.
    if (target_wr) begin
      state_d = S_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          if (enable_q && (target_q > duty_q))      state_d = S_UP;
          else if (enable_q && (target_q < duty_q)) state_d = S_DOWN;
        end
        S_UP: begin
          if (!enable_q) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else if (tick) begin
            presc_d = '0;
            if (sum9 >= {1'b0, target_q}) begin
              duty_d     = target_q;
              irq_pend_d = 1'b1;  // placed after the W1C so set wins
              state_d    = S_IDLE;
            end else begin
              duty_d = sum9[7:0];
            end
          end else begin
            // Free-running increment: if PERIOD drops below the count the
            // counter wraps through its maximum before the next tick.
            presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
          end
        end
        S_DOWN: begin
          if (!enable_q) begin
            state_d = S_IDLE;
            presc_d = '0;
          end else if (tick) begin
            presc_d = '0;
            if (diff8 <= step_eff) begin
              duty_d     = target_q;
              irq_pend_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              duty_d = duty_q - step_eff;
            end
          end else begin
            presc_d = presc_q + {{(PRESC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end

    if (read) begin
      case (address)
        2'd0:    readdata_d = {24'd0, target_q};
        2'd1:    readdata_d = {24'd0, step_q};
        2'd2:    readdata_d = {{(32-PRESC_W){1'b0}}, period_q};
        default: readdata_d = status;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      duty_q     <= 8'd0;
      target_q   <= 8'd0;
      step_q     <= 8'd1;
      period_q   <= '0;
      presc_q    <= '0;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      busy_q     <= (state_d != S_IDLE);
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign duty     = duty_q;
  assign busy     = busy_q;
  assign irq      = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb/tb_pwm_ramp_controller.sv - scoreboard bench for pwm_ramp_controller

module tb_pwm_ramp_controller;

  localparam int P_DUTY  = 0;
  localparam int P_BUSY  = 1;
  localparam int P_IRQ   = 2;
  localparam int P_RDATA = 3;
  localparam int LIMIT   = 5000;

  typedef struct {
    int          edge_n;
    int          pin;
    logic [31:0] val;
    string       name;
  } pexp_t;

  typedef struct {
    int         edge_n;
    logic [7:0] val;
  } dexp_t;

  typedef struct {
    logic [31:0] val;
    string       name;
  } rexp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [7:0]  duty;
  logic        busy;
  logic        irq;

  pexp_t pq[$];
  dexp_t dq[$];
  rexp_t rq[$];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;
  logic rd_seen = 1'b0;
  logic [7:0] prev_duty = 8'd0;

  pwm_ramp_controller #(.PRESC_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .read      (read),
    .readdata  (readdata),
    .duty      (duty),
    .busy      (busy),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_seen <= read;
  end

  // Scoreboard monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_read readdata=%h", readdata);
      end else begin
        rexp_t r;
        r = rq.pop_front();
        checks++;
        if (readdata !== r.val) begin
          failures++;
          $display("FAIL %s readdata=%h expected=%h", r.name, readdata, r.val);
        end
      end
    end

    if (duty !== prev_duty) begin
      if (dq.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_duty_change duty=%0d at edge %0d", duty, cyc);
      end else begin
        dexp_t d;
        d = dq.pop_front();
        checks++;
        if (duty !== d.val || cyc != d.edge_n) begin
          failures++;
          $display("FAIL duty_step duty=%0d edge=%0d expected duty=%0d edge=%0d",
                   duty, cyc, d.val, d.edge_n);
        end
      end
    end
    prev_duty = duty;

    while (pq.size() > 0 && pq[0].edge_n <= cyc) begin
      pexp_t p;
      logic [31:0] act;
      p = pq.pop_front();
      case (p.pin)
        P_DUTY:  act = {24'd0, duty};
        P_BUSY:  act = {31'd0, busy};
        P_IRQ:   act = {31'd0, irq};
        default: act = readdata;
      endcase
      checks++;
      if (p.edge_n < cyc) begin
        failures++;
        $display("FAIL %s not sampled at edge %0d (now %0d)", p.name, p.edge_n, cyc);
      end else if (act !== p.val) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h", p.name, act, p.val);
      end
    end

    if (done || cyc > LIMIT) begin
      if (cyc > LIMIT) begin
        failures++;
        $display("FAIL timeout at edge %0d", cyc);
      end
      foreach (dq[i]) begin
        failures++;
        $display("FAIL missing_duty_step duty=none expected=%0d at edge %0d", dq[i].val, dq[i].edge_n);
      end
      foreach (rq[i]) begin
        failures++;
        $display("FAIL %s readdata=none expected=%h", rq[i].name, rq[i].val);
      end
      foreach (pq[i]) begin
        failures++;
        $display("FAIL %s never sampled expected=%h", pq[i].name, pq[i].val);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // All stimulus tasks are entered on a falling edge; a write or read is
  // sampled on the next rising edge, which equals cyc when the task returns.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write     = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp_v, input string name);
    rexp_t r;
    r.val  = exp_v;
    r.name = name;
    rq.push_back(r);
    address = a;
    read    = 1'b1;
    @(negedge clk);
    read    = 1'b0;
  endtask

  task automatic pexp(input int e, input int pin, input logic [31:0] v, input string name);
    pexp_t p;
    p.edge_n = e;
    p.pin    = pin;
    p.val    = v;
    p.name   = name;
    pq.push_back(p);
  endtask

  task automatic dexp(input logic [7:0] v, input int e);
    dexp_t d;
    d.val    = v;
    d.edge_n = e;
    dq.push_back(d);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic clr(input logic [31:0] ctrl, input string name);
    pexp(cyc + 1, P_IRQ, 32'd0, name);
    wr(2'd3, ctrl);
  endtask

  int n, m, p, r;

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; address = 2'd0; writedata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    pexp(cyc + 1, P_DUTY,  32'd0, "rst_duty");
    pexp(cyc + 1, P_BUSY,  32'd0, "rst_busy");
    pexp(cyc + 1, P_IRQ,   32'd0, "rst_irq");
    pexp(cyc + 1, P_RDATA, 32'd0, "rst_readdata");
    @(negedge clk);
    rd(2'd1, 32'd1, "rst_step");
    rd(2'd0, 32'd0, "rst_target");
    rd(2'd2, 32'd0, "rst_period");

    // Ramp up 0 -> 35, STEP 10, PERIOD 3
    wr(2'd1, 32'd10); wr(2'd2, 32'd3); wr(2'd3, 32'd3);
    wr(2'd0, 32'd35); n = cyc;
    dexp(8'd10, n + 5); dexp(8'd20, n + 9); dexp(8'd30, n + 13); dexp(8'd35, n + 17);
    pexp(n + 1,  P_BUSY, 32'd1, "up_busy");
    pexp(n + 16, P_IRQ,  32'd0, "up_irq_early");
    pexp(n + 17, P_IRQ,  32'd1, "up_irq_done");
    pexp(n + 17, P_BUSY, 32'd0, "up_busy_done");
    wait_until(n + 17);
    rd(2'd3, 32'h0000_2307, "up_status");
    clr(32'd7, "up_irq_clear");

    // Ramp down 35 -> 0, STEP 16, PERIOD 0
    wr(2'd1, 32'd16); wr(2'd2, 32'd0);
    wr(2'd0, 32'd0); n = cyc;
    dexp(8'd19, n + 2); dexp(8'd3, n + 3); dexp(8'd0, n + 4);
    pexp(n + 3, P_IRQ,  32'd0, "down_irq_early");
    pexp(n + 4, P_IRQ,  32'd1, "down_irq_done");
    pexp(n + 4, P_BUSY, 32'd0, "down_busy_done");
    wait_until(n + 4);
    rd(2'd3, 32'h0000_0007, "down_status");
    clr(32'd7, "down_irq_clear");

    // Retarget on the tick edge at duty 20: that step is suppressed
    wr(2'd1, 32'd10); wr(2'd2, 32'd3);
    wr(2'd0, 32'd35); n = cyc;
    dexp(8'd10, n + 5); dexp(8'd20, n + 9);
    wait_until(n + 12);
    wr(2'd0, 32'd5); m = cyc;
    dexp(8'd10, m + 5); dexp(8'd5, m + 9);
    pexp(m + 1, P_BUSY, 32'd1, "retarget_busy");
    pexp(m + 8, P_IRQ,  32'd0, "retarget_irq_early");
    pexp(m + 9, P_IRQ,  32'd1, "retarget_irq_done");
    wait_until(m + 9);
    rd(2'd3, 32'h0000_0507, "retarget_status");
    clr(32'd7, "retarget_irq_clear");

    // Pause at duty 25, then resume to 45
    wr(2'd0, 32'd45); n = cyc;
    dexp(8'd15, n + 5); dexp(8'd25, n + 9);
    wait_until(n + 9);
    wr(2'd3, 32'd2); p = cyc;
    pexp(p + 1, P_BUSY, 32'd0, "pause_busy");
    pexp(p + 8, P_IRQ,  32'd0, "pause_irq");
    wait_until(p + 8);
    rd(2'd3, 32'h0000_1902, "pause_status");
    wr(2'd3, 32'd3); r = cyc;
    dexp(8'd35, r + 5); dexp(8'd45, r + 9);
    pexp(r + 1, P_BUSY, 32'd1, "resume_busy");
    pexp(r + 9, P_IRQ,  32'd1, "resume_irq_done");
    wait_until(r + 9);
    clr(32'd7, "resume_irq_clear");

    // STEP=0 behaves as 1
    wr(2'd1, 32'd0); wr(2'd2, 32'd0);
    wr(2'd0, 32'd47); n = cyc;
    dexp(8'd46, n + 2); dexp(8'd47, n + 3);
    pexp(n + 3, P_IRQ, 32'd1, "step0_irq");
    wait_until(n + 3);
    clr(32'd7, "step0_irq_clear");

    // STEP=255: single-step down to 0, then single-step up to 255
    wr(2'd1, 32'd255);
    wr(2'd0, 32'd0); n = cyc;
    dexp(8'd0, n + 2);
    wait_until(n + 2);
    clr(32'd7, "s255_down_clear");
    wr(2'd0, 32'd255); n = cyc;
    dexp(8'd255, n + 2);
    pexp(n + 2, P_BUSY, 32'd0, "s255_busy_done");
    pexp(n + 3, P_IRQ,  32'd1, "w1c_on_final_step");
    wait_until(n + 1);
    wr(2'd3, 32'd7);
    rd(2'd3, 32'h0000_FF07, "w1c_final_status");

    // Target equal to duty: no ramp, no irq
    clr(32'd7, "eq_pre_clear");
    wr(2'd0, 32'd255); n = cyc;
    pexp(n + 1, P_BUSY, 32'd0, "eq_busy1");
    pexp(n + 2, P_BUSY, 32'd0, "eq_busy2");
    pexp(n + 3, P_IRQ,  32'd0, "eq_irq");
    wait_until(n + 3);
    rd(2'd3, 32'h0000_FF03, "eq_status");

    // Asynchronous reset just after a step edge, mid-ramp
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd0); n = cyc;
    dexp(8'd254, n + 2); dexp(8'd0, n + 3);
    pexp(n + 3, P_DUTY,  32'd0, "arst_duty");
    pexp(n + 3, P_BUSY,  32'd0, "arst_busy");
    pexp(n + 3, P_IRQ,   32'd0, "arst_irq");
    pexp(n + 3, P_RDATA, 32'd0, "arst_readdata");
    wait_until(n + 2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd1, 32'd1, "arst_step");
    rd(2'd3, 32'd0, "arst_status");
    repeat (3) @(negedge clk);
    done = 1'b1;
  end

endmodule
